serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_pkg.sv | 13 +
 rtl/half_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 118 +++++++++++
 tb/tb_serial_subtractor.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types for the bit-serial subtractor.
// State encoding and default operand width.
package serial_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: difference and borrow out.
// Two of these plus an OR form a full subtractor bit.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);

  assign d  = a ^ b;
  assign bo = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per RUN cycle.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed overflow output ovf.
module serial_subtractor
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             d1;
  logic             bo1;
  logic             dbit;
  logic             bo2;
  logic             bout;
  logic             last;
  logic [WIDTH-1:0] nxt;

  half_subtractor u_hs1 (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .d  (d1),
    .bo (bo1)
  );

  half_subtractor u_hs2 (
    .a  (d1),
    .b  (bin),
    .d  (dbit),
    .bo (bo2)
  );

  assign bout = bo1 | bo2;
  assign nxt  = {dbit, res};
  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // res holds the WIDTH-1 low bits; the last bit goes straight into d.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      d      <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      a_sh <= a;
      b_sh <= b;
      bin  <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      bin  <= bout;
      res  <= nxt[WIDTH-1:1];
      cnt  <= cnt + CW'(1);
      if (last) begin
        d      <= nxt;
        borrow <= bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        // a_sh[0]/b_sh[0] are the operand sign bits on the last step.
        ovf    <= (a_sh[0] ^ b_sh[0]) & (dbit ^ a_sh[0]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor, WIDTH=8.
// Checks ovf too when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .d      (d),
    .borrow (borrow)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic [W-1:0] ed,
                       input logic eb, input logic eo);
    int n;
    int nb;
    start = 1'b1;
    a = ia;
    b = ib;
    step();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n = 1;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      step();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(W + 1));
    chk({tag, "_busy"}, 32'(nb), 32'(W));
    chk({tag, "_d"}, 32'(d), 32'(ed));
    chk({tag, "_bor"}, 32'(borrow), 32'(eb));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo) begin end
`endif
    step();
    chk({tag, "_pulse"}, 32'(done), 32'(0));
    chk({tag, "_hold"}, 32'(d), 32'(ed));
  endtask

  initial begin
    int np;
    int t;
    int last_t;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_d", 32'(d), 32'(0));
    chk("rst_bor", 32'(borrow), 32'(0));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'(0));
`endif
    rst = 1'b0;
    step();

    do_op("5m3", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    do_op("3m5", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    do_op("0m0", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    do_op("ffmff", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    do_op("80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    do_op("10m01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
    do_op("0m1", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    do_op("7fmff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Second start during RUN must be ignored.
    start = 1'b1; a = 8'd9; b = 8'd4;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1; a = 8'd1; b = 8'd7;
    step();
    start = 1'b0;
    np = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        np++;
        chk("ign_d", 32'(d), 32'h05);
      end
      step();
    end
    chk("ign_pulses", 32'(np), 32'(1));

    // Reset in the middle of RUN aborts the operation.
    start = 1'b1; a = 8'd9; b = 8'd4;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_d", 32'(d), 32'(0));
    chk("abort_bor", 32'(borrow), 32'(0));
    np = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) np++;
      step();
    end
    chk("abort_nodone", 32'(np), 32'(0));
    do_op("7m2", 8'd7, 8'd2, 8'h05, 1'b0, 1'b0);

    // start held high: back-to-back operations.
    start = 1'b1; a = 8'd6; b = 8'd1;
    np = 0;
    last_t = 0;
    for (t = 0; t < 45; t++) begin
      if (done) begin
        chk("b2b_d", 32'(d), 32'h05);
        if (np > 0) chk("b2b_period", 32'(t - last_t), 32'(W + 2));
        else chk("b2b_first", 32'(t), 32'(W + 1));
        last_t = t;
        np++;
      end
      step();
    end
    chk("b2b_pulses", 32'(np), 32'(4));
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
